// File: rtl/dma_arb_pkg.sv
// Shared widths and command payload for the DMA read arbiter.
package dma_arb_pkg;

    localparam int unsigned ADDR_W            = 64;
    localparam int unsigned LEN_W             = 32;
    localparam int unsigned DEFAULT_N_CLIENTS = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [LEN_W-1:0]  length;
    } dma_cmd_t;

endpackage

// File: rtl/dma_read_arbiter_if.sv
// Client-side and DMA-side handshake bundle; master is the arbiter, slave the environment.
interface dma_read_arbiter_if
    import dma_arb_pkg::*;
#(
    parameter int unsigned N_CLIENTS = DEFAULT_N_CLIENTS,
    parameter int unsigned WIDTH     = 512
);

    localparam int unsigned KEEP_W = WIDTH / 8;

    logic [N_CLIENTS-1:0]             client_cmd_valid;
    logic [N_CLIENTS-1:0]             client_cmd_ready;
    logic [N_CLIENTS-1:0][ADDR_W-1:0] client_cmd_address;
    logic [N_CLIENTS-1:0][LEN_W-1:0]  client_cmd_length;

    logic [N_CLIENTS-1:0]             client_data_valid;
    logic [N_CLIENTS-1:0]             client_data_ready;
    logic [WIDTH-1:0]                 client_data_data;
    logic [KEEP_W-1:0]                client_data_keep;
    logic                             client_data_last;

    logic                             read_cmd_valid;
    logic                             read_cmd_ready;
    logic [ADDR_W-1:0]                read_cmd_address;
    logic [LEN_W-1:0]                 read_cmd_length;

    logic                             read_data_valid;
    logic                             read_data_ready;
    logic [WIDTH-1:0]                 read_data_data;
    logic [KEEP_W-1:0]                read_data_keep;
    logic                             read_data_last;

    modport master (
        input  client_cmd_valid, client_cmd_address, client_cmd_length, client_data_ready,
               read_cmd_ready, read_data_valid, read_data_data, read_data_keep, read_data_last,
        output client_cmd_ready, client_data_valid, client_data_data, client_data_keep,
               client_data_last, read_cmd_valid, read_cmd_address, read_cmd_length,
               read_data_ready
    );

    modport slave (
        output client_cmd_valid, client_cmd_address, client_cmd_length, client_data_ready,
               read_cmd_ready, read_data_valid, read_data_data, read_data_keep, read_data_last,
        input  client_cmd_ready, client_data_valid, client_data_data, client_data_keep,
               client_data_last, read_cmd_valid, read_cmd_address, read_cmd_length,
               read_data_ready
    );

endinterface

// File: rtl/arb_order_fifo.sv
// Order FIFO of granted client indices; head tells the data path who owns the next response.
module arb_order_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter of N client read commands onto one DMA read port, with in-order data return.
module dma_read_arbiter
    import dma_arb_pkg::*;
#(
    parameter int unsigned N_CLIENTS   = DEFAULT_N_CLIENTS,
    parameter int unsigned WIDTH       = 512,
    parameter int unsigned ORDER_DEPTH = 16
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    dma_read_arbiter_if.master           bus,
    output logic [$clog2(ORDER_DEPTH):0] outstanding_o,
    output logic [31:0]                  dropped_count_o,
    output logic                         orphan_error_o
);

    localparam int unsigned IDX_W      = $clog2(N_CLIENTS);
    localparam int unsigned KEEP_BYTES = WIDTH / 8;

    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [31:0]          dropped_q, dropped_d;
    logic                 orphan_q, orphan_d;

    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_found;
    int unsigned          cand;
    dma_cmd_t             grant_cmd;
    logic                 zero_beat, can_accept, cmd_fire, drop_fire;
    logic [N_CLIENTS-1:0] cmd_ready_c, data_valid_c;

    logic [IDX_W-1:0]     head_idx;
    logic                 order_full, order_empty, data_ok, order_pop;

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= N_CLIENTS) cand = cand - N_CLIENTS;
            if (!grant_found && bus.client_cmd_valid[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        grant_cmd.address = bus.client_cmd_address[grant_idx];
        grant_cmd.length  = bus.client_cmd_length[grant_idx];
    end

    // Commands shorter than one beat are absorbed here and never reach the DMA.
    assign zero_beat  = (grant_cmd.length < LEN_W'(KEEP_BYTES));
    assign can_accept = grant_found && !order_full && !reset_i;
    assign cmd_fire   = can_accept && !zero_beat && bus.read_cmd_ready;
    assign drop_fire  = can_accept && zero_beat;

    always_comb begin
        cmd_ready_c = '0;
        if (cmd_fire || drop_fire) cmd_ready_c[grant_idx] = 1'b1;
    end

    assign bus.client_cmd_ready = cmd_ready_c;
    assign bus.read_cmd_valid   = can_accept && !zero_beat;
    assign bus.read_cmd_address = grant_cmd.address;
    assign bus.read_cmd_length  = grant_cmd.length;

    arb_order_fifo #(
        .DEPTH  (ORDER_DEPTH),
        .DATA_W (IDX_W)
    ) u_order_fifo (
        .clk_i       (clock_i),
        .rst_i       (reset_i),
        .push_i      (cmd_fire),
        .push_data_i (grant_idx),
        .pop_i       (order_pop),
        .head_o      (head_idx),
        .full_o      (order_full),
        .empty_o     (order_empty),
        .count_o     (outstanding_o)
    );

    // Response beats go to whichever client owns the oldest outstanding command.
    assign data_ok             = !order_empty && !reset_i;
    assign bus.read_data_ready = data_ok && bus.client_data_ready[head_idx];
    assign order_pop           = bus.read_data_valid && bus.read_data_ready && bus.read_data_last;

    always_comb begin
        data_valid_c = '0;
        if (data_ok && bus.read_data_valid) data_valid_c[head_idx] = 1'b1;
    end

    assign bus.client_data_valid = data_valid_c;
    assign bus.client_data_data  = bus.read_data_data;
    assign bus.client_data_keep  = bus.read_data_keep;
    assign bus.client_data_last  = bus.read_data_last;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        dropped_d = dropped_q;
        orphan_d  = orphan_q | (bus.read_data_valid && order_empty);
        if (cmd_fire || drop_fire) begin
            rr_ptr_d = (grant_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
        if (drop_fire) dropped_d = dropped_q + 32'd1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_ptr_q  <= '0;
            dropped_q <= '0;
            orphan_q  <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            dropped_q <= dropped_d;
            orphan_q  <= orphan_d;
        end
    end

    assign dropped_count_o = dropped_q;
    assign orphan_error_o  = orphan_q;

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Directed bench for dma_read_arbiter: arbitration order, zero-beat drops, full FIFO, stalls, orphans, reset.
module tb_dma_read_arbiter;
    import dma_arb_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 512;
    localparam int unsigned D = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  outstanding;
    logic [31:0] dropped;
    logic        orphan;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    dma_read_arbiter_if #(.N_CLIENTS(N), .WIDTH(W)) dif ();

    dma_read_arbiter #(
        .N_CLIENTS   (N),
        .WIDTH       (W),
        .ORDER_DEPTH (D)
    ) dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .bus             (dif),
        .outstanding_o   (outstanding),
        .dropped_count_o (dropped),
        .orphan_error_o  (orphan)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int unsigned b, input logic last);
        dif.read_data_data = {8{64'h0000_0000_0000_B000 + 64'(b)}};
        dif.read_data_keep = '1;
        dif.read_data_last = last;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_g [5];
        logic        stall_rdy [5];
        int unsigned stall_beat [5];
        exp_g      = '{0, 1, 2, 3, 0};
        stall_rdy  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        stall_beat = '{0, 1, 1, 2, 3};

        // Reset: everything held quiet even with stimulus present.
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            dif.client_cmd_address[i] = 64'h1000 * 64'(i + 1);
            dif.client_cmd_length[i]  = 32'd128;
        end
        dif.client_cmd_valid  = 4'b1111;
        dif.client_data_ready = 4'b1111;
        dif.read_cmd_ready    = 1'b1;
        dif.read_data_valid   = 1'b1;
        set_beat(0, 1'b0);
        #1;
        check_eq("rst_cmd_ready", 64'(dif.client_cmd_ready), 64'h0);
        check_eq("rst_read_cmd_valid", 64'(dif.read_cmd_valid), 64'h0);
        check_eq("rst_read_data_ready", 64'(dif.read_data_ready), 64'h0);
        check_eq("rst_client_data_valid", 64'(dif.client_data_valid), 64'h0);
        tick();
        check_eq("rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("rst_dropped", 64'(dropped), 64'd0);
        check_eq("rst_orphan", 64'(orphan), 64'd0);
        dif.client_cmd_valid = 4'b0000;
        dif.read_data_valid  = 1'b0;
        dif.client_data_ready = 4'b0000;
        rst = 1'b0;
        tick();

        // Round robin: four clients all requesting, DMA stalled then ready.
        dif.client_cmd_valid = 4'b1111;
        dif.read_cmd_ready   = 1'b0;
        #1;
        check_eq("stall_read_cmd_valid", 64'(dif.read_cmd_valid), 64'h1);
        check_eq("stall_cmd_ready", 64'(dif.client_cmd_ready), 64'h0);
        dif.read_cmd_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            check_eq($sformatf("rr_grant%0d", g), 64'(dif.client_cmd_ready), 64'(4'b0001 << exp_g[g]));
            check_eq($sformatf("rr_addr%0d", g), dif.read_cmd_address, 64'h1000 * 64'(exp_g[g] + 1));
            tick();
        end
        dif.client_cmd_valid = 4'b0000;
        #1;
        check_eq("rr_outstanding", 64'(outstanding), 64'd5);

        // Two beats per command, delivered in grant order.
        dif.client_data_ready = 4'b1111;
        dif.read_data_valid   = 1'b1;
        for (int j = 0; j < 10; j++) begin
            set_beat(j, (j % 2) == 1);
            #1;
            check_eq($sformatf("rr_route%0d", j), 64'(dif.client_data_valid), 64'(4'b0001 << exp_g[j / 2]));
            check_eq($sformatf("rr_data%0d", j), dif.client_data_data[63:0], 64'hB000 + 64'(j));
            tick();
        end
        dif.read_data_valid = 1'b0;
        #1;
        check_eq("rr_drained", 64'(outstanding), 64'd0);

        // Zero-length command from client 2 (rr_ptr = 1).
        dif.client_cmd_length[2] = 32'd0;
        dif.client_cmd_valid     = 4'b0100;
        #1;
        check_eq("zero_cmd_ready", 64'(dif.client_cmd_ready), 64'h4);
        check_eq("zero_read_cmd_valid", 64'(dif.read_cmd_valid), 64'h0);
        tick();
        dif.client_cmd_valid = 4'b0000;
        #1;
        check_eq("zero_dropped", 64'(dropped), 64'd1);
        check_eq("zero_outstanding", 64'(outstanding), 64'd0);

        // 63 bytes is still under one beat; accepted even with the DMA not ready.
        dif.client_cmd_length[1] = 32'd63;
        dif.read_cmd_ready       = 1'b0;
        dif.client_cmd_valid     = 4'b0010;
        #1;
        check_eq("short_cmd_ready", 64'(dif.client_cmd_ready), 64'h2);
        check_eq("short_read_cmd_valid", 64'(dif.read_cmd_valid), 64'h0);
        tick();
        dif.client_cmd_valid = 4'b0000;
        dif.read_cmd_ready   = 1'b1;
        #1;
        check_eq("short_dropped", 64'(dropped), 64'd2);
        dif.client_cmd_length[1] = 32'd128;
        dif.client_cmd_length[2] = 32'd128;

        // Fill the order FIFO from client 3 with data stalled.
        dif.client_cmd_length[3] = 32'd64;
        dif.client_cmd_valid     = 4'b1000;
        for (int i = 0; i < D; i++) tick();
        check_eq("full_outstanding", 64'(outstanding), 64'd16);
        check_eq("full_cmd_ready", 64'(dif.client_cmd_ready), 64'h0);
        check_eq("full_read_cmd_valid", 64'(dif.read_cmd_valid), 64'h0);
        dif.client_cmd_length[0] = 32'd0;
        dif.client_cmd_valid     = 4'b1001;
        #1;
        check_eq("full_zero_ready", 64'(dif.client_cmd_ready), 64'h0);
        tick();
        check_eq("full_zero_dropped", 64'(dropped), 64'd2);

        // One last beat frees a slot; a new command is then taken.
        dif.client_cmd_length[0] = 32'd128;
        dif.client_cmd_valid     = 4'b1000;
        dif.client_data_ready    = 4'b1000;
        dif.read_data_valid      = 1'b1;
        set_beat(100, 1'b1);
        #1;
        check_eq("full_pop_ready", 64'(dif.read_data_ready), 64'h1);
        check_eq("full_pop_route", 64'(dif.client_data_valid), 64'h8);
        tick();
        dif.read_data_valid = 1'b0;
        #1;
        check_eq("pop_outstanding", 64'(outstanding), 64'd15);
        check_eq("refill_cmd_ready", 64'(dif.client_cmd_ready), 64'h8);
        tick();
        dif.client_cmd_valid = 4'b0000;
        #1;
        check_eq("refill_outstanding", 64'(outstanding), 64'd16);
        dif.client_data_ready = 4'b1111;
        dif.read_data_valid   = 1'b1;
        set_beat(101, 1'b1);
        for (int i = 0; i < D; i++) tick();
        dif.read_data_valid = 1'b0;
        #1;
        check_eq("full_drained", 64'(outstanding), 64'd0);

        // Four-beat response to client 1 with its ready toggling.
        dif.client_cmd_length[1] = 32'd256;
        dif.client_cmd_valid     = 4'b0010;
        #1;
        check_eq("burst_cmd_ready", 64'(dif.client_cmd_ready), 64'h2);
        tick();
        dif.client_cmd_valid = 4'b0000;
        dif.read_data_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            set_beat(stall_beat[c], stall_beat[c] == 3);
            dif.client_data_ready = {2'b00, stall_rdy[c], 1'b0};
            #1;
            check_eq($sformatf("burst_ready%0d", c), 64'(dif.read_data_ready), 64'(stall_rdy[c]));
            check_eq($sformatf("burst_route%0d", c), 64'(dif.client_data_valid), 64'h2);
            check_eq($sformatf("burst_data%0d", c), dif.client_data_data[511:448], 64'hB000 + 64'(stall_beat[c]));
            tick();
            check_eq($sformatf("burst_outstanding%0d", c), 64'(outstanding), (c == 4) ? 64'd0 : 64'd1);
        end
        dif.read_data_valid = 1'b0;
        dif.client_cmd_length[1] = 32'd128;

        // Orphan beat with nothing outstanding.
        dif.client_data_ready = 4'b1111;
        dif.read_data_valid   = 1'b1;
        set_beat(7, 1'b0);
        #1;
        check_eq("orphan_ready", 64'(dif.read_data_ready), 64'h0);
        check_eq("orphan_route", 64'(dif.client_data_valid), 64'h0);
        check_eq("orphan_before", 64'(orphan), 64'h0);
        tick();
        check_eq("orphan_set", 64'(orphan), 64'h1);
        dif.read_data_valid = 1'b0;
        tick();
        tick();
        check_eq("orphan_sticky", 64'(orphan), 64'h1);

        // Reset with three commands outstanding (rr_ptr = 2: grants 2,3,1).
        dif.client_cmd_valid = 4'b1110;
        tick();
        tick();
        tick();
        dif.client_cmd_valid = 4'b0000;
        #1;
        check_eq("pre_rst_outstanding", 64'(outstanding), 64'd3);
        rst = 1'b1;
        dif.client_cmd_valid = 4'b1111;
        #1;
        check_eq("mid_rst_cmd_ready", 64'(dif.client_cmd_ready), 64'h0);
        check_eq("mid_rst_read_cmd_valid", 64'(dif.read_cmd_valid), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("post_rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("post_rst_orphan", 64'(orphan), 64'h0);
        check_eq("post_rst_dropped", 64'(dropped), 64'd0);
        check_eq("post_rst_grant", 64'(dif.client_cmd_ready), 64'h1);
        check_eq("post_rst_addr", dif.read_cmd_address, 64'h1000);
        tick();
        dif.client_cmd_valid = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
